// File: rtl/sfx_voice_mixer_if.sv
// ROM fetch bus between the voice mixer and its two sample ROMs.
// The mixer drives both addresses; each ROM returns its byte one Clk later.
interface sfx_voice_mixer_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] rom0_addr;
    logic [7:0]        rom0_data;
    logic [ADDR_W-1:0] rom1_addr;
    logic [7:0]        rom1_data;

    modport master (
        output rom0_addr,
        output rom1_addr,
        input  rom0_data,
        input  rom1_data
    );

    modport slave (
        input  rom0_addr,
        input  rom1_addr,
        output rom0_data,
        output rom1_data
    );
endinterface

// File: rtl/sfx_voice_mixer.sv
// Two-voice one-shot sound-effect player: one fetch/mix pass per LRCLK rising edge,
// saturating mix of both voices into an MSB-justified 32-bit i2s_out DIN word.
module sfx_voice_mixer #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned LEN0   = 17646,
    parameter int unsigned LEN1   = 12000
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    LRCLK,
    input  logic                    trig0,
    input  logic                    trig1,
    input  logic                    mute,
    sfx_voice_mixer_if.master       rom,
    output logic [31:0]             audio_word,
    output logic                    busy0,
    output logic                    busy1,
    output logic                    done0,
    output logic                    done1
);
    localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);

    // The LOAD step is taken in IDLE on the tick itself, so the
    // pass is LOAD (tick edge), WAIT (ROM access), MIX (capture + write).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_MIX  = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] lr_sync;
    logic       trig0_q;
    logic       trig1_q;
    logic       pend0;
    logic       pend1;

    logic       tick_c;
    logic       edge0_c;
    logic       edge1_c;
    logic [7:0] d0_c;
    logic [7:0] d1_c;
    logic [8:0] s0_c;
    logic [8:0] s1_c;
    logic [8:0] sum_c;
    logic [7:0] sat_c;

    assign tick_c  = lr_sync[1] & ~lr_sync[2];
    assign edge0_c = trig0 & ~trig0_q;
    assign edge1_c = trig1 & ~trig1_q;

    // Offset-binary to signed, idle voices silent, clamp on 9-bit overflow.
    always_comb begin
        d0_c  = rom.rom0_data ^ 8'h80;
        d1_c  = rom.rom1_data ^ 8'h80;
        s0_c  = busy0 ? {d0_c[7], d0_c} : 9'd0;
        s1_c  = busy1 ? {d1_c[7], d1_c} : 9'd0;
        sum_c = s0_c + s1_c;
        sat_c = sum_c[7:0];
        if (sum_c[8] != sum_c[7]) begin
            sat_c = sum_c[8] ? 8'h80 : 8'h7F;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_IDLE;
            lr_sync       <= 3'b000;
            trig0_q       <= 1'b0;
            trig1_q       <= 1'b0;
            pend0         <= 1'b0;
            pend1         <= 1'b0;
            rom.rom0_addr <= '0;
            rom.rom1_addr <= '0;
            audio_word    <= 32'd0;
            busy0         <= 1'b0;
            busy1         <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
        end else begin
            lr_sync <= {lr_sync[1:0], LRCLK};
            trig0_q <= trig0;
            trig1_q <= trig1;
            done0   <= 1'b0;
            done1   <= 1'b0;
            pend0   <= pend0 | edge0_c;
            pend1   <= pend1 | edge1_c;

            case (state)
                S_IDLE: begin
                    if (tick_c) begin
                        // Starting (or restarting) a voice consumes its pending trigger.
                        if (pend0 || edge0_c) begin
                            rom.rom0_addr <= '0;
                            busy0         <= 1'b1;
                            pend0         <= 1'b0;
                        end
                        if (pend1 || edge1_c) begin
                            rom.rom1_addr <= '0;
                            busy1         <= 1'b1;
                            pend1         <= 1'b0;
                        end
                        state <= S_WAIT;
                    end
                end
                S_WAIT: state <= S_MIX;
                S_MIX: begin
                    audio_word <= mute ? 32'd0 : {sat_c, 24'h000000};
                    if (busy0) begin
                        if (rom.rom0_addr == LAST0) begin
                            busy0         <= 1'b0;
                            rom.rom0_addr <= '0;
                            done0         <= 1'b1;
                        end else begin
                            rom.rom0_addr <= rom.rom0_addr + ADDR_W'(1);
                        end
                    end
                    if (busy1) begin
                        if (rom.rom1_addr == LAST1) begin
                            busy1         <= 1'b0;
                            rom.rom1_addr <= '0;
                            done1         <= 1'b1;
                        end else begin
                            rom.rom1_addr <= rom.rom1_addr + ADDR_W'(1);
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Scoreboard bench for sfx_voice_mixer: a per-tick reference model pushes the expected
// word/status, which is popped and compared when the mix pass completes.
module tb_sfx_voice_mixer;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned LEN0   = 600;
    localparam int unsigned LEN1   = 400;

    typedef struct {
        logic [31:0] word;
        logic        b0;
        logic        b1;
        logic        d0;
        logic        d1;
        int          a0;
        int          a1;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        lrclk = 1'b0;
    logic        trig0 = 1'b0;
    logic        trig1 = 1'b0;
    logic        mute  = 1'b0;
    logic [31:0] audio_word;
    logic        busy0, busy1, done0, done1;

    logic        f0_en  = 1'b0;
    logic        f1_en  = 1'b0;
    logic [7:0]  f0_val = 8'h00;
    logic [7:0]  f1_val = 8'h00;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [31:0] prev_word = 32'd0;

    int          m_addr0 = 0, m_addr1 = 0;
    bit          m_busy0 = 0, m_busy1 = 0, m_pend0 = 0, m_pend1 = 0;

    sfx_voice_mixer_if #(.ADDR_W(ADDR_W)) rom_bus ();

    sfx_voice_mixer #(.ADDR_W(ADDR_W), .LEN0(LEN0), .LEN1(LEN1)) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .LRCLK      (lrclk),
        .trig0      (trig0),
        .trig1      (trig1),
        .mute       (mute),
        .rom        (rom_bus),
        .audio_word (audio_word),
        .busy0      (busy0),
        .busy1      (busy1),
        .done0      (done0),
        .done1      (done1)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample ROMs with optional forced contents.
    always @(posedge clk) begin
        rom_bus.rom0_data <= f0_en ? f0_val : rom_bus.rom0_addr[7:0];
        rom_bus.rom1_data <= f1_en ? f1_val : (rom_bus.rom1_addr[7:0] ^ 8'h5A);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom0f(input int a);
        return f0_en ? f0_val : 8'(a);
    endfunction

    function automatic logic [7:0] rom1f(input int a);
        return f1_en ? f1_val : (8'(a) ^ 8'h5A);
    endfunction

    task automatic model_reset();
        m_addr0 = 0; m_addr1 = 0;
        m_busy0 = 0; m_busy1 = 0;
        m_pend0 = 0; m_pend1 = 0;
        prev_word = 32'd0;
    endtask

    // One LRCLK period; late0 raises trig0 during the WAIT cycle of this pass.
    task automatic do_tick(input bit late0);
        exp_t        e;
        logic [7:0]  v0, v1;
        int          s;
        lrclk = 1'b1;
        if (m_pend0) begin m_addr0 = 0; m_busy0 = 1; m_pend0 = 0; end
        if (m_pend1) begin m_addr1 = 0; m_busy1 = 1; m_pend1 = 0; end
        v0 = m_busy0 ? (rom0f(m_addr0) ^ 8'h80) : 8'h00;
        v1 = m_busy1 ? (rom1f(m_addr1) ^ 8'h80) : 8'h00;
        s  = int'($signed(v0)) + int'($signed(v1));
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        e.word = mute ? 32'd0 : {8'(s), 24'h000000};
        e.d0 = m_busy0 && (m_addr0 == int'(LEN0) - 1);
        e.d1 = m_busy1 && (m_addr1 == int'(LEN1) - 1);
        if (m_busy0) begin
            if (e.d0) begin m_busy0 = 0; m_addr0 = 0; end else m_addr0++;
        end
        if (m_busy1) begin
            if (e.d1) begin m_busy1 = 0; m_addr1 = 0; end else m_addr1++;
        end
        e.b0 = m_busy0; e.b1 = m_busy1; e.a0 = m_addr0; e.a1 = m_addr1;
        q.push_back(e);

        repeat (3) @(posedge clk);
        #1;
        if (late0) begin trig0 = 1'b1; m_pend0 = 1; end
        @(posedge clk); #1;
        chk("latency_hold", audio_word, prev_word);
        @(posedge clk); #1;
        e = q.pop_front();
        chk("word",  audio_word, e.word);
        chk("busy0", 32'(busy0), 32'(e.b0));
        chk("busy1", 32'(busy1), 32'(e.b1));
        chk("done0", 32'(done0), 32'(e.d0));
        chk("done1", 32'(done1), 32'(e.d1));
        chk("addr0", 32'(rom_bus.rom0_addr), 32'(e.a0));
        chk("addr1", 32'(rom_bus.rom1_addr), 32'(e.a1));
        prev_word = e.word;
        lrclk = 1'b0;
        @(posedge clk); #1;
        chk("done0_width", 32'(done0), 32'd0);
        chk("done1_width", 32'(done1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        if (late0) trig0 = 1'b0;
    endtask

    task automatic pulse_trig(input bit t0, input bit t1);
        if (t0) begin trig0 = 1'b1; m_pend0 = 1; end
        if (t1) begin trig1 = 1'b1; m_pend1 = 1; end
        repeat (2) @(posedge clk);
        #1;
        trig0 = 1'b0;
        trig1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for Clk.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_word",  audio_word, 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_addr0", 32'(rom_bus.rom0_addr), 32'd0);
        chk("rst_addr1", 32'(rom_bus.rom1_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_done0", 32'(done0), 32'd0);
            chk("rst_done1", 32'(done1), 32'd0);
        end
        trig0 = 1'b0; trig1 = 1'b0; mute = 1'b0; lrclk = 1'b0;
        f0_en = 1'b0; f1_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        apply_reset();
        run_ticks(1);

        // Reset aborts voice 0 at address 500.
        pulse_trig(1'b1, 1'b0);
        run_ticks(500);
        chk("pre_rst_addr0", 32'(rom_bus.rom0_addr), 32'd500);
        apply_reset();

        // Full playback of voice 0, then silence.
        pulse_trig(1'b1, 1'b0);
        run_ticks(int'(LEN0) + 2);

        // Saturation corners with both voices playing.
        apply_reset();
        f0_en = 1'b1; f1_en = 1'b1; f0_val = 8'hFF; f1_val = 8'hFF;
        pulse_trig(1'b1, 1'b1);
        run_ticks(1);
        chk("sat_pos", audio_word, 32'h7F000000);
        f0_val = 8'h00; f1_val = 8'h00;
        run_ticks(1);
        chk("sat_neg", audio_word, 32'h80000000);
        f0_val = 8'hC0; f1_val = 8'h40;
        run_ticks(1);
        chk("sat_zero", audio_word, 32'h00000000);

        // Retrigger voice 1 mid-playback, then let it finish.
        apply_reset();
        pulse_trig(1'b0, 1'b1);
        run_ticks(100);
        pulse_trig(1'b0, 1'b1);
        run_ticks(1);
        chk("retrig_addr1", 32'(rom_bus.rom1_addr), 32'd1);
        run_ticks(int'(LEN1) + 1);

        // Held trigger level starts playback only once.
        apply_reset();
        trig1 = 1'b1; m_pend1 = 1;
        run_ticks(100);
        chk("held_addr1", 32'(rom_bus.rom1_addr), 32'd100);
        trig1 = 1'b0;
        run_ticks(2);

        // Trigger edge during WAIT waits for the following pass.
        apply_reset();
        do_tick(1'b1);
        chk("late_idle", 32'(busy0), 32'd0);
        run_ticks(3);

        // Mute for 5 ticks from address 10; playback keeps advancing.
        apply_reset();
        pulse_trig(1'b1, 1'b0);
        run_ticks(10);
        mute = 1'b1;
        run_ticks(5);
        mute = 1'b0;
        run_ticks(1);
        chk("mute_resume", audio_word, 32'h8F000000);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
